// File: rtl/id_branch_predict_resolve.sv
// ID-stage branch/jump resolve unit with IF-stage prediction.
// IF looks up a direct-mapped BHT of saturating counters and a tagged BTB.
// ID resolves the real outcome with EX/MEM and MEM/WB forwarding and
// redirects only on a mispredict. Training is applied one cycle after resolve.
// Optional feature macro: BP_PERF_CNT_EN adds branch / mispredict counters.
module id_branch_predict_resolve #(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BHT_DEPTH   = 64,
  parameter int unsigned BTB_DEPTH   = 16,
  parameter int unsigned CNT_WIDTH   = 2,
  parameter int unsigned ALUOP_WIDTH = 4,
  parameter int unsigned RADDR_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PC_WIDTH-1:0]    if_pc,
  output logic                   pred_taken,
  output logic [PC_WIDTH-1:0]    pred_target,
  input  logic                   id_valid,
  input  logic                   id_stall,
  input  logic [PC_WIDTH-1:0]    id_pc,
  input  logic                   id_pred_taken,
  input  logic [PC_WIDTH-1:0]    id_pred_target,
  input  logic                   branch_jump,
  input  logic                   alu_src,
  input  logic [ALUOP_WIDTH-1:0] alu_op,
  input  logic                   id_reg_read1,
  input  logic [RADDR_WIDTH-1:0] id_reg_rs1,
  input  logic [RADDR_WIDTH-1:0] id_reg_rs2,
  input  logic [RADDR_WIDTH-1:0] exmem_reg_dest,
  input  logic [RADDR_WIDTH-1:0] memwb_reg_dest,
  input  logic                   exmem_reg_write,
  input  logic                   memwb_reg_write,
  input  logic [DATA_WIDTH-1:0]  exmem_reg_wdata,
  input  logic [DATA_WIDTH-1:0]  wb_reg_wdata,
  input  logic [DATA_WIDTH-1:0]  reg_rdata1,
  input  logic [DATA_WIDTH-1:0]  reg_rdata2,
  input  logic [DATA_WIDTH-1:0]  imm,
  output logic [PC_WIDTH-1:0]    target_pc,
  output logic                   flush_pipeline,
  output logic                   pc_src
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]            perf_branch_cnt,
  output logic [31:0]            perf_mispred_cnt
`endif
);

  localparam int unsigned BHT_IDX_W = $clog2(BHT_DEPTH);
  localparam int unsigned BTB_IDX_W = $clog2(BTB_DEPTH);
  localparam int unsigned TAG_W     = PC_WIDTH - BTB_IDX_W - 2;
  localparam int unsigned UPC_W     = PC_WIDTH - 2;

  localparam logic [ALUOP_WIDTH-1:0] ALU_EQ    = ALUOP_WIDTH'(0);
  localparam logic [ALUOP_WIDTH-1:0] ALU_NE    = ALUOP_WIDTH'(1);
  localparam logic [ALUOP_WIDTH-1:0] ALU_LT    = ALUOP_WIDTH'(2);
  localparam logic [ALUOP_WIDTH-1:0] ALU_GE    = ALUOP_WIDTH'(3);
  localparam logic [ALUOP_WIDTH-1:0] ALU_LTU   = ALUOP_WIDTH'(4);
  localparam logic [ALUOP_WIDTH-1:0] ALU_GEU   = ALUOP_WIDTH'(5);
  localparam logic [ALUOP_WIDTH-1:0] ALU_ADDPC = ALUOP_WIDTH'(6);

  localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [PC_WIDTH-1:0]  PC_FOUR = PC_WIDTH'(4);

  // Prediction tables
  logic [CNT_WIDTH-1:0] bht_q       [BHT_DEPTH];
  logic                 btb_valid_q [BTB_DEPTH];
  logic [TAG_W-1:0]     btb_tag_q   [BTB_DEPTH];
  logic [PC_WIDTH-1:0]  btb_tgt_q   [BTB_DEPTH];
  logic                 btb_jal_q   [BTB_DEPTH];

  // Update pipeline register
  logic              upd_valid_q,  upd_valid_d;
  logic [UPC_W-1:0]  upd_pc_q,     upd_pc_d;
  logic              upd_taken_q,  upd_taken_d;
  logic [PC_WIDTH-1:0] upd_target_q, upd_target_d;
  logic              upd_branch_q, upd_branch_d;
  logic              upd_jal_q,    upd_jal_d;
  logic              upd_jalr_q,   upd_jalr_d;
  logic              upd_alias_q,  upd_alias_d;

  logic [BHT_IDX_W-1:0] if_bht_idx;
  logic [BTB_IDX_W-1:0] if_btb_idx;
  logic [TAG_W-1:0]     if_tag;
  logic                 if_hit;
  logic                 if_taken;

  logic [DATA_WIDTH-1:0] op1, rs2_val, op2;
  logic                  is_jmp, is_branch, is_jal, is_jalr;
  logic                  cmp_taken, actual_taken;
  logic [PC_WIDTH-1:0]   br_target, jalr_sum, actual_target;
  logic                  id_go, resolve, alias_mis, ctl_mis, mispredict;

  logic [BHT_IDX_W-1:0] u_bht_idx;
  logic [BTB_IDX_W-1:0] u_btb_idx;
  logic [CNT_WIDTH-1:0] bht_cur, bht_next;
  logic                 btb_alloc;

  // IF lookup: BTB hit plus BHT direction or unconditional JAL
  always_comb begin
    if_bht_idx  = if_pc[BHT_IDX_W+1:2];
    if_btb_idx  = if_pc[BTB_IDX_W+1:2];
    if_tag      = if_pc[PC_WIDTH-1:BTB_IDX_W+2];
    if_hit      = btb_valid_q[if_btb_idx] && (btb_tag_q[if_btb_idx] == if_tag);
    if_taken    = rst_n && if_hit && (btb_jal_q[if_btb_idx] || bht_q[if_bht_idx][CNT_WIDTH-1]);
    pred_taken  = if_taken;
    pred_target = if_taken ? btb_tgt_q[if_btb_idx] : if_pc + PC_FOUR;
  end

  // Operand forwarding: EX/MEM over MEM/WB over register file; r0 never forwards
  always_comb begin
    op1 = reg_rdata1;
    if (exmem_reg_write && (exmem_reg_dest != '0) && (exmem_reg_dest == id_reg_rs1)) begin
      op1 = exmem_reg_wdata;
    end else if (memwb_reg_write && (memwb_reg_dest != '0) && (memwb_reg_dest == id_reg_rs1)) begin
      op1 = wb_reg_wdata;
    end
    rs2_val = reg_rdata2;
    if (exmem_reg_write && (exmem_reg_dest != '0) && (exmem_reg_dest == id_reg_rs2)) begin
      rs2_val = exmem_reg_wdata;
    end else if (memwb_reg_write && (memwb_reg_dest != '0) && (memwb_reg_dest == id_reg_rs2)) begin
      rs2_val = wb_reg_wdata;
    end
    op2 = alu_src ? imm : rs2_val;
  end

  // Actual outcome and mispredict detection
  always_comb begin
    is_jmp    = branch_jump && (alu_op == ALU_ADDPC);
    is_branch = branch_jump && !is_jmp;
    is_jal    = is_jmp && !id_reg_read1;
    is_jalr   = is_jmp && id_reg_read1;

    case (alu_op)
      ALU_EQ:  cmp_taken = (op1 == op2);
      ALU_NE:  cmp_taken = (op1 != op2);
      ALU_LT:  cmp_taken = ($signed(op1) <  $signed(op2));
      ALU_GE:  cmp_taken = ($signed(op1) >= $signed(op2));
      ALU_LTU: cmp_taken = (op1 <  op2);
      ALU_GEU: cmp_taken = (op1 >= op2);
      default: cmp_taken = 1'b0;
    endcase

    br_target     = id_pc + PC_WIDTH'(imm);
    jalr_sum      = PC_WIDTH'(op1 + imm);
    actual_taken  = is_jmp || (is_branch && cmp_taken);
    actual_target = is_jalr ? (jalr_sum & ~PC_WIDTH'(1)) : br_target;

    id_go     = rst_n && id_valid && !id_stall;
    resolve   = id_go && branch_jump;
    alias_mis = id_go && !branch_jump && id_pred_taken;
    ctl_mis   = resolve && ((actual_taken != id_pred_taken) ||
                            (actual_taken && (actual_target != id_pred_target)));
    mispredict = ctl_mis || alias_mis;

    flush_pipeline = mispredict;
    pc_src         = mispredict;
    target_pc      = '0;
    if (mispredict) begin
      target_pc = actual_taken ? actual_target : id_pc + PC_FOUR;
    end
  end

  // Next value of the update register: capture on resolve or BTB alias
  always_comb begin
    upd_valid_d  = resolve || alias_mis;
    upd_pc_d     = id_pc[PC_WIDTH-1:2];
    upd_taken_d  = actual_taken;
    upd_target_d = actual_target;
    upd_branch_d = is_branch;
    upd_jal_d    = is_jal;
    upd_jalr_d   = is_jalr;
    upd_alias_d  = alias_mis;
  end

  // Update register; a reset discards any pending update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_valid_q  <= 1'b0;
      upd_pc_q     <= '0;
      upd_taken_q  <= 1'b0;
      upd_target_q <= '0;
      upd_branch_q <= 1'b0;
      upd_jal_q    <= 1'b0;
      upd_jalr_q   <= 1'b0;
      upd_alias_q  <= 1'b0;
    end else begin
      upd_valid_q  <= upd_valid_d;
      upd_pc_q     <= upd_pc_d;
      upd_taken_q  <= upd_taken_d;
      upd_target_q <= upd_target_d;
      upd_branch_q <= upd_branch_d;
      upd_jal_q    <= upd_jal_d;
      upd_jalr_q   <= upd_jalr_d;
      upd_alias_q  <= upd_alias_d;
    end
  end

  // Training values: saturating counter step and BTB allocate decision
  always_comb begin
    u_bht_idx = upd_pc_q[BHT_IDX_W-1:0];
    u_btb_idx = upd_pc_q[BTB_IDX_W-1:0];
    bht_cur   = bht_q[u_bht_idx];
    bht_next  = bht_cur;
    if (upd_taken_q && (bht_cur != CNT_MAX)) begin
      bht_next = bht_cur + CNT_WIDTH'(1);
    end else if (!upd_taken_q && (bht_cur != '0)) begin
      bht_next = bht_cur - CNT_WIDTH'(1);
    end
    btb_alloc = upd_taken_q && !upd_jalr_q && (upd_branch_q || upd_jal_q);
  end

  // Table write; IF reads the pre-write contents in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_DEPTH; i++) begin
        bht_q[BHT_IDX_W'(i)] <= CNT_RST;
      end
      for (int unsigned j = 0; j < BTB_DEPTH; j++) begin
        btb_valid_q[BTB_IDX_W'(j)] <= 1'b0;
        btb_tag_q[BTB_IDX_W'(j)]   <= '0;
        btb_tgt_q[BTB_IDX_W'(j)]   <= '0;
        btb_jal_q[BTB_IDX_W'(j)]   <= 1'b0;
      end
    end else if (upd_valid_q) begin
      if (upd_branch_q) begin
        bht_q[u_bht_idx] <= bht_next;
      end
      if (btb_alloc) begin
        btb_valid_q[u_btb_idx] <= 1'b1;
        btb_tag_q[u_btb_idx]   <= upd_pc_q[UPC_W-1:BTB_IDX_W];
        btb_tgt_q[u_btb_idx]   <= upd_target_q;
        btb_jal_q[u_btb_idx]   <= upd_jal_q;
      end else if (upd_alias_q) begin
        btb_valid_q[u_btb_idx] <= 1'b0;
      end
    end
  end

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branch_q, perf_mispred_q;

  // Free-running resolve and mispredict event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branch_q  <= '0;
      perf_mispred_q <= '0;
    end else begin
      if (resolve)    perf_branch_q  <= perf_branch_q + 32'd1;
      if (mispredict) perf_mispred_q <= perf_mispred_q + 32'd1;
    end
  end

  assign perf_branch_cnt  = perf_branch_q;
  assign perf_mispred_cnt = perf_mispred_q;
`else
  // No performance counters in this build
`endif

endmodule

// File: tb/tb_id_branch_predict_resolve.sv
// Directed bench for id_branch_predict_resolve: vector table for ID resolve,
// hand sequences for prediction training, stall and reset corners.
module tb_id_branch_predict_resolve;

  localparam logic [3:0] OP_EQ = 4'd0, OP_NE = 4'd1, OP_LT = 4'd2, OP_GE = 4'd3;
  localparam logic [3:0] OP_LTU = 4'd4, OP_GEU = 4'd5, OP_ADDPC = 4'd6;

  logic        clk, rst_n;
  logic [31:0] if_pc, pred_target, id_pc, id_pred_target;
  logic        pred_taken, id_valid, id_stall, id_pred_taken;
  logic        branch_jump, alu_src, id_reg_read1;
  logic [3:0]  alu_op;
  logic [4:0]  id_reg_rs1, id_reg_rs2, exmem_reg_dest, memwb_reg_dest;
  logic        exmem_reg_write, memwb_reg_write;
  logic [31:0] exmem_reg_wdata, wb_reg_wdata, reg_rdata1, reg_rdata2, imm;
  logic [31:0] target_pc;
  logic        flush_pipeline, pc_src;
`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_branch_cnt, perf_mispred_cnt;
`endif

  int tests = 0;
  int fails = 0;

  id_branch_predict_resolve dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .id_valid(id_valid), .id_stall(id_stall),
    .id_pc(id_pc), .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
    .branch_jump(branch_jump), .alu_src(alu_src), .alu_op(alu_op),
    .id_reg_read1(id_reg_read1), .id_reg_rs1(id_reg_rs1), .id_reg_rs2(id_reg_rs2),
    .exmem_reg_dest(exmem_reg_dest), .memwb_reg_dest(memwb_reg_dest),
    .exmem_reg_write(exmem_reg_write), .memwb_reg_write(memwb_reg_write),
    .exmem_reg_wdata(exmem_reg_wdata), .wb_reg_wdata(wb_reg_wdata),
    .reg_rdata1(reg_rdata1), .reg_rdata2(reg_rdata2), .imm(imm),
    .target_pc(target_pc), .flush_pipeline(flush_pipeline), .pc_src(pc_src)
`ifdef BP_PERF_CNT_EN
    , .perf_branch_cnt(perf_branch_cnt), .perf_mispred_cnt(perf_mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        valid, stall, bj, rd1, asrc;
    logic [3:0]  op;
    logic [4:0]  rs1, rs2;
    logic        ex_we, wb_we;
    logic [4:0]  ex_rd, wb_rd;
    logic [31:0] ex_wd, wb_wd, a, b, im, pc;
    logic        ptk;
    logic [31:0] ptgt;
    logic        ef;
    logic [31:0] et;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(string nm, logic bj, logic [3:0] op, logic rd1,
                              logic [31:0] a, logic [31:0] b, logic [31:0] im,
                              logic ptk, logic [31:0] ptgt, logic ef, logic [31:0] et);
    vec_t v;
    v.nm = nm; v.valid = 1'b1; v.stall = 1'b0; v.bj = bj; v.rd1 = rd1; v.asrc = 1'b0;
    v.op = op; v.rs1 = 5'd1; v.rs2 = 5'd2; v.ex_we = 1'b0; v.wb_we = 1'b0;
    v.ex_rd = 5'd0; v.wb_rd = 5'd0; v.ex_wd = 32'h0; v.wb_wd = 32'h0;
    v.a = a; v.b = b; v.im = im; v.pc = 32'h200; v.ptk = ptk; v.ptgt = ptgt;
    v.ef = ef; v.et = et;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_valid = 0; id_stall = 0; branch_jump = 0; alu_src = 0; alu_op = OP_EQ;
    id_reg_read1 = 0; id_pc = 0; id_pred_taken = 0; id_pred_target = 0;
    id_reg_rs1 = 5'd1; id_reg_rs2 = 5'd2; exmem_reg_write = 0; memwb_reg_write = 0;
    exmem_reg_dest = 0; memwb_reg_dest = 0; exmem_reg_wdata = 0; wb_reg_wdata = 0;
    reg_rdata1 = 0; reg_rdata2 = 0; imm = 0;
  endtask

  task automatic drive(input logic bj, input logic [31:0] pc, input logic [3:0] op,
                       input logic rd1, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] im, input logic ptk, input logic [31:0] ptgt);
    idle();
    id_valid = 1; branch_jump = bj; id_pc = pc; alu_op = op; id_reg_read1 = rd1;
    reg_rdata1 = a; reg_rdata2 = b; imm = im; id_pred_taken = ptk; id_pred_target = ptgt;
  endtask

  task automatic chk_id(input string nm, input logic ef, input logic [31:0] et);
    chk({nm, ".flush"}, 32'(flush_pipeline), 32'(ef));
    chk({nm, ".pc_src"}, 32'(pc_src), 32'(ef));
    chk({nm, ".target_pc"}, target_pc, et);
  endtask

  task automatic look(input string nm, input logic [31:0] pc, input logic tk,
                      input logic [31:0] tgt);
    if_pc = pc;
    #1;
    chk({nm, ".pred_taken"}, 32'(pred_taken), 32'(tk));
    chk({nm, ".pred_target"}, pred_target, tgt);
  endtask

  // One ID instruction for a single cycle, then two idle edges so training lands
  task automatic issue(input string nm, input logic bj, input logic [31:0] pc,
                       input logic [3:0] op, input logic rd1, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] im, input logic ptk,
                       input logic [31:0] ptgt, input logic ef, input logic [31:0] et);
    @(negedge clk);
    drive(bj, pc, op, rd1, a, b, im, ptk, ptgt);
    #1;
    chk_id(nm, ef, et);
    @(negedge clk);
    idle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    // Resolve vectors, all at id_pc 0x200 unless noted
    vt.push_back(mk("beq_eq",    1, OP_EQ,  0, 32'd5, 32'd5, 32'h20, 0, 32'h0, 1, 32'h220));
    vt.push_back(mk("beq_ne",    1, OP_EQ,  0, 32'd5, 32'd6, 32'h20, 0, 32'h0, 0, 32'h0));
    vt.push_back(mk("bne_ok",    1, OP_NE,  0, 32'd5, 32'd6, 32'h20, 1, 32'h220, 0, 32'h0));
    vt.push_back(mk("blt_s",     1, OP_LT,  0, 32'hFFFFFFFF, 32'd1, 32'h20, 0, 32'h0, 1, 32'h220));
    vt.push_back(mk("bltu",      1, OP_LTU, 0, 32'hFFFFFFFF, 32'd1, 32'h20, 1, 32'h220, 1, 32'h204));
    vt.push_back(mk("bge_s",     1, OP_GE,  0, 32'hFFFFFFFF, 32'd1, 32'h20, 0, 32'h0, 0, 32'h0));
    vt.push_back(mk("bgeu_tgt",  1, OP_GEU, 0, 32'hFFFFFFFF, 32'd1, 32'h20, 1, 32'h300, 1, 32'h220));
    vt.push_back(mk("bad_op",    1, 4'hF,   0, 32'd5, 32'd5, 32'h20, 0, 32'h0, 0, 32'h0));
    vt.push_back(mk("beq_neg",   1, OP_EQ,  0, 32'd3, 32'd3, 32'hFFFFFFF8, 0, 32'h0, 1, 32'h1F8));
    vt.push_back(mk("jal",       1, OP_ADDPC, 0, 32'd0, 32'd0, 32'h100, 0, 32'h0, 1, 32'h300));
    vt.push_back(mk("jalr_ok",   1, OP_ADDPC, 1, 32'h1000, 32'd0, 32'h11, 1, 32'h1010, 0, 32'h0));
    vt.push_back(mk("alias",     0, OP_EQ,  0, 32'd0, 32'd0, 32'h0, 1, 32'h220, 1, 32'h204));
    vt.push_back(mk("nonctl",    0, OP_EQ,  0, 32'd0, 32'd0, 32'h0, 0, 32'h0, 0, 32'h0));
    v = mk("bubble", 1, OP_EQ, 0, 32'd5, 32'd5, 32'h20, 0, 32'h0, 0, 32'h0);
    v.valid = 0; vt.push_back(v);
    v = mk("stall", 1, OP_EQ, 0, 32'd5, 32'd5, 32'h20, 0, 32'h0, 0, 32'h0);
    v.stall = 1; vt.push_back(v);
    v = mk("jalr_fwd_ex", 1, OP_ADDPC, 1, 32'h9000, 32'd0, 32'h4, 0, 32'h0, 1, 32'h2004);
    v.rs1 = 5'd5; v.ex_we = 1; v.ex_rd = 5'd5; v.ex_wd = 32'h2001; vt.push_back(v);
    v = mk("jalr_x0", 1, OP_ADDPC, 1, 32'h3000, 32'd0, 32'h4, 0, 32'h0, 1, 32'h3004);
    v.rs1 = 5'd0; v.ex_we = 1; v.ex_rd = 5'd0; v.ex_wd = 32'h2001; vt.push_back(v);
    v = mk("fwd_prio", 1, OP_EQ, 0, 32'h99, 32'h77, 32'h20, 0, 32'h0, 1, 32'h220);
    v.rs1 = 5'd5; v.rs2 = 5'd6; v.ex_we = 1; v.ex_rd = 5'd5; v.ex_wd = 32'h77;
    v.wb_we = 1; v.wb_rd = 5'd5; v.wb_wd = 32'h88; vt.push_back(v);
    v = mk("fwd_wb", 1, OP_EQ, 0, 32'd5, 32'd9, 32'h20, 0, 32'h0, 1, 32'h220);
    v.rs2 = 5'd6; v.wb_we = 1; v.wb_rd = 5'd6; v.wb_wd = 32'd5; vt.push_back(v);
    v = mk("alu_src_imm", 1, OP_EQ, 0, 32'h20, 32'd0, 32'h20, 0, 32'h0, 1, 32'h220);
    v.asrc = 1; vt.push_back(v);

    // Outputs held quiet during reset even with a mispredicting branch in ID
    rst_n = 0;
    idle();
    if_pc = 32'h100;
    drive(1, 32'h100, OP_EQ, 0, 32'd7, 32'd7, 32'h40, 0, 32'h0);
    #1;
    chk_id("in_reset", 0, 32'h0);
    look("in_reset", 32'h100, 0, 32'h104);
    @(negedge clk);
    idle();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    chk_id("post_reset", 0, 32'h0);
    look("post_reset", 32'h100, 0, 32'h104);
`ifdef BP_PERF_CNT_EN
    chk("perf_branch_rst", perf_branch_cnt, 32'd0);
    chk("perf_mispred_rst", perf_mispred_cnt, 32'd0);
`endif

    foreach (vt[i]) begin
      @(negedge clk);
      idle();
      id_valid = vt[i].valid; id_stall = vt[i].stall; branch_jump = vt[i].bj;
      alu_op = vt[i].op; id_reg_read1 = vt[i].rd1; alu_src = vt[i].asrc;
      id_reg_rs1 = vt[i].rs1; id_reg_rs2 = vt[i].rs2;
      exmem_reg_write = vt[i].ex_we; exmem_reg_dest = vt[i].ex_rd; exmem_reg_wdata = vt[i].ex_wd;
      memwb_reg_write = vt[i].wb_we; memwb_reg_dest = vt[i].wb_rd; wb_reg_wdata = vt[i].wb_wd;
      reg_rdata1 = vt[i].a; reg_rdata2 = vt[i].b; imm = vt[i].im; id_pc = vt[i].pc;
      id_pred_taken = vt[i].ptk; id_pred_target = vt[i].ptgt;
      #1;
      chk_id(vt[i].nm, vt[i].ef, vt[i].et);
    end
    do_reset();

    // Cold BEQ at 0x100: mispredict, then trained one cycle later
    drive(1, 32'h100, OP_EQ, 0, 32'd7, 32'd7, 32'h40, 0, 32'h0);
    #1;
    chk_id("cold_beq", 1, 32'h140);
    @(negedge clk);
    idle();
    look("cold_pending", 32'h100, 0, 32'h104);
    @(negedge clk);
    look("cold_trained", 32'h100, 1, 32'h140);
    look("tag_miss", 32'h200, 0, 32'h204);

    // Counter 10 -> 11 -> 11 (saturate), then 11 -> 10 -> 01
    issue("beq_hit1", 1, 32'h100, OP_EQ, 0, 32'd7, 32'd7, 32'h40, 1, 32'h140, 0, 32'h0);
    issue("beq_hit2", 1, 32'h100, OP_EQ, 0, 32'd7, 32'd7, 32'h40, 1, 32'h140, 0, 32'h0);
    issue("bne_nt1", 1, 32'h100, OP_NE, 0, 32'd7, 32'd7, 32'h40, 1, 32'h140, 1, 32'h104);
    look("after_nt1", 32'h100, 1, 32'h140);
    issue("bne_nt2", 1, 32'h100, OP_NE, 0, 32'd7, 32'd7, 32'h40, 1, 32'h140, 1, 32'h104);
    look("after_nt2", 32'h100, 0, 32'h104);
    issue("beq_retrain", 1, 32'h100, OP_EQ, 0, 32'd7, 32'd7, 32'h40, 0, 32'h0, 1, 32'h140);
    look("retrained", 32'h100, 1, 32'h140);

    // BTB alias on a non-control instruction invalidates the entry
    issue("alias_clr", 0, 32'h100, OP_EQ, 0, 32'd0, 32'd0, 32'h0, 1, 32'h140, 1, 32'h104);
    look("alias_cleared", 32'h100, 0, 32'h104);

    // JAL predicts taken through is_jal with a weak counter; JALR never allocates
    issue("jal_cold", 1, 32'h308, OP_ADDPC, 0, 32'd0, 32'd0, 32'h80, 0, 32'h0, 1, 32'h388);
    look("jal_pred", 32'h308, 1, 32'h388);
    issue("jalr_cold", 1, 32'h40C, OP_ADDPC, 1, 32'h2001, 32'd0, 32'h4, 0, 32'h0, 1, 32'h2004);
    look("jalr_noalloc", 32'h40C, 0, 32'h410);

    // Stall holds off flush and training; release resolves once
    @(negedge clk);
    drive(1, 32'h110, OP_EQ, 0, 32'd7, 32'd7, 32'h10, 0, 32'h0);
    id_stall = 1;
    #1;
    chk_id("stall_c1", 0, 32'h0);
    @(negedge clk);
    #1;
    chk_id("stall_c2", 0, 32'h0);
    @(negedge clk);
    look("stall_notrain", 32'h110, 0, 32'h114);
    id_stall = 0;
    #1;
    chk_id("stall_release", 1, 32'h120);
    @(negedge clk);
    idle();
    #1;
    chk_id("stall_once", 0, 32'h0);
    @(negedge clk);
    look("stall_trained", 32'h110, 1, 32'h120);

    // Reset with an update pending: pending discarded, tables back to reset
    issue("r_t1", 1, 32'h120, OP_EQ, 0, 32'd7, 32'd7, 32'h20, 0, 32'h0, 1, 32'h140);
    issue("r_t2", 1, 32'h120, OP_EQ, 0, 32'd7, 32'd7, 32'h20, 1, 32'h140, 0, 32'h0);
    @(negedge clk);
    drive(1, 32'h120, OP_EQ, 0, 32'd7, 32'd7, 32'h20, 0, 32'h0);
    #1;
    chk_id("r_pending", 1, 32'h140);
    @(negedge clk);
    rst_n = 0;
    idle();
    look("r_during", 32'h120, 0, 32'h124);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    @(negedge clk);
    look("r_btb120", 32'h120, 0, 32'h124);
    look("r_btb110", 32'h110, 0, 32'h114);
    look("r_btb308", 32'h308, 0, 32'h30C);
`ifdef BP_PERF_CNT_EN
    chk("perf_branch_midrst", perf_branch_cnt, 32'd0);
    chk("perf_mispred_midrst", perf_mispred_cnt, 32'd0);
`endif
    issue("r_t3", 1, 32'h120, OP_EQ, 0, 32'd7, 32'd7, 32'h20, 0, 32'h0, 1, 32'h140);
    look("r_t3_pred", 32'h120, 1, 32'h140);
`ifdef BP_PERF_CNT_EN
    chk("perf_branch_one", perf_branch_cnt, 32'd1);
    chk("perf_mispred_one", perf_mispred_cnt, 32'd1);
`endif
    issue("r_nt", 1, 32'h120, OP_NE, 0, 32'd7, 32'd7, 32'h20, 1, 32'h140, 1, 32'h124);
    look("r_cnt_reset", 32'h120, 0, 32'h124);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
